decoder_scan_n: RTL and testbench

Parametrised, registered SEL_W-to-2^SEL_W one-hot decoder with two modes.
- Direct mode: decodes data_in.
- Scan mode: an internal index counter sweeps every output line, holding each one for DWELL cycles. Typical uses are row/digit scanning and round-robin channel strobes.
- Replaces ad-hoc combinational decoders wherever a registered, glitch-free select bus is needed.

---
 rtl/decod_pkg.sv | 25 ++
 rtl/decod_next_idx.sv | 34 +++
 rtl/decoder_scan_n.sv | 138 +++++++++++++
 tb/tb_decoder_scan_n.sv | 181 ++++++++++++++++++
 4 files changed

// File: rtl/decod_pkg.sv
// Shared types and helpers for the registered one-hot scan decoder.
package decod_pkg;

    typedef enum logic {
        MODE_DIRECT = 1'b0,
        MODE_SCAN   = 1'b1
    } decod_mode_e;

    localparam int unsigned DEFAULT_DWELL = 4;

    // Widest select bus supported (SEL_W up to 6).
    localparam int unsigned MAX_OUT_W = 64;

    // One-hot code of idx; all zeros when idx falls outside the bus width.
    function automatic logic [MAX_OUT_W-1:0] onehot(input int unsigned idx,
                                                    input int unsigned width);
        logic [MAX_OUT_W-1:0] v;
        v = '0;
        if (idx < width) begin
            v = {{(MAX_OUT_W-1){1'b0}}, 1'b1} << idx;
        end
        return v;
    endfunction

endpackage

// File: rtl/decod_next_idx.sv
// Circular priority search for the next unmasked line after cur_idx.
// The search covers cur_idx+1 .. cur_idx+OUT_W, so a lone free line finds itself.
module decod_next_idx
    import decod_pkg::*;
#(
    parameter int unsigned SEL_W = 2
) (
    input  logic [SEL_W-1:0]    cur_idx,
    input  logic [2**SEL_W-1:0] mask,
    output logic [SEL_W-1:0]    nxt_idx,
    output logic                wrapped,
    output logic                none_free
);

    localparam int unsigned OUT_W = 2**SEL_W;

    logic [SEL_W-1:0] cand;

    // Walk candidates farthest-first so the nearest free line wins last.
    always_comb begin
        nxt_idx   = cur_idx;
        none_free = 1'b1;
        cand      = '0;
        for (int k = OUT_W; k >= 1; k--) begin
            cand = cur_idx + SEL_W'(k);
            if (!mask[cand]) begin
                nxt_idx   = cand;
                none_free = 1'b0;
            end
        end
        wrapped = !none_free && (nxt_idx <= cur_idx);
    end

endmodule

// File: rtl/decoder_scan_n.sv
// Registered SEL_W-to-2**SEL_W one-hot decoder with direct and scan modes.
// Optional feature: DECODER_SCAN_SKIP_MASK_EN adds skip_mask to skip lines while scanning.
module decoder_scan_n
    import decod_pkg::*;
#(
    parameter int unsigned SEL_W = 2,
    parameter int unsigned DWELL = DEFAULT_DWELL
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                enable,
    input  logic                mode,
    input  logic [SEL_W-1:0]    data_in,
`ifdef DECODER_SCAN_SKIP_MASK_EN
    input  logic [2**SEL_W-1:0] skip_mask,
`endif
    output logic [2**SEL_W-1:0] out,
    output logic [SEL_W-1:0]    out_idx,
    output logic                out_valid,
    output logic                wrap
);

    localparam int unsigned OUT_W = 2**SEL_W;
    localparam int unsigned DW    = (DWELL > 1) ? $clog2(DWELL) : 1;
    localparam logic [DW-1:0] DwellLast = DW'(DWELL - 1);

    decod_mode_e      mode_q, mode_d, mode_in;
    logic [SEL_W-1:0] idx_q, idx_d, out_idx_q, out_idx_d;
    logic [DW-1:0]    dwell_q, dwell_d;
    logic [OUT_W-1:0] out_q, out_d;
    logic             valid_q, valid_d, wrap_q, wrap_d;
    // A wrap seen at an advance, waiting for its new line to reach the output.
    logic             pend_q, pend_d;

    logic             mode_chg;
    logic [SEL_W-1:0] cur_idx, adv_idx;
    logic [DW-1:0]    cur_dwell;
    logic [OUT_W-1:0] line_mask;
    logic             adv_wrap, adv_none;

    assign mode_in   = decod_mode_e'(mode);
    assign mode_chg  = (mode_in != mode_q);
    // A mode change restarts the sweep in the same cycle so line 0 gets a full dwell.
    assign cur_idx   = mode_chg ? '0 : idx_q;
    assign cur_dwell = mode_chg ? '0 : dwell_q;

`ifdef DECODER_SCAN_SKIP_MASK_EN
    assign line_mask = skip_mask;

    decod_next_idx #(
        .SEL_W (SEL_W)
    ) u_next_idx (
        .cur_idx   (cur_idx),
        .mask      (skip_mask),
        .nxt_idx   (adv_idx),
        .wrapped   (adv_wrap),
        .none_free (adv_none)
    );
`else
    assign line_mask = '0;
    assign adv_idx   = cur_idx + SEL_W'(1);
    assign adv_wrap  = (cur_idx == SEL_W'(OUT_W - 1));
    assign adv_none  = 1'b0;
`endif

    // Next-state for index, dwell, mode tracking and the registered select bus.
    always_comb begin
        idx_d     = idx_q;
        dwell_d   = dwell_q;
        mode_d    = mode_q;
        out_idx_d = out_idx_q;
        pend_d    = pend_q;
        out_d     = '0;
        valid_d   = 1'b0;
        wrap_d    = 1'b0;
        if (enable) begin
            mode_d = mode_in;
            if (mode_chg) begin
                idx_d   = '0;
                dwell_d = '0;
                pend_d  = 1'b0;
            end
            if (mode_in == MODE_DIRECT) begin
                out_idx_d = data_in;
                if (!line_mask[data_in]) begin
                    out_d   = OUT_W'(onehot(32'(data_in), OUT_W));
                    valid_d = 1'b1;
                end
            end else begin
                out_idx_d = cur_idx;
                if (!line_mask[cur_idx]) begin
                    out_d   = OUT_W'(onehot(32'(cur_idx), OUT_W));
                    valid_d = 1'b1;
                end
                wrap_d = pend_q && !mode_chg;
                pend_d = 1'b0;
                if (cur_dwell == DwellLast) begin
                    dwell_d = '0;
                    if (!adv_none) begin
                        idx_d  = adv_idx;
                        pend_d = adv_wrap;
                    end
                end else begin
                    dwell_d = cur_dwell + DW'(1);
                end
            end
        end
    end

    // State and output registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            idx_q     <= '0;
            dwell_q   <= '0;
            mode_q    <= MODE_DIRECT;
            out_idx_q <= '0;
            out_q     <= '0;
            valid_q   <= 1'b0;
            wrap_q    <= 1'b0;
            pend_q    <= 1'b0;
        end else begin
            idx_q     <= idx_d;
            dwell_q   <= dwell_d;
            mode_q    <= mode_d;
            out_idx_q <= out_idx_d;
            out_q     <= out_d;
            valid_q   <= valid_d;
            wrap_q    <= wrap_d;
            pend_q    <= pend_d;
        end
    end

    assign out       = out_q;
    assign out_idx   = out_idx_q;
    assign out_valid = valid_q;
    assign wrap      = wrap_q;

endmodule

// File: tb/tb_decoder_scan_n.sv
// Bench for decoder_scan_n: two instances (SEL_W=2/DWELL=4 and SEL_W=3/DWELL=1)
// driven by shared control and checked against a cycle-count reference model.
module tb_decoder_scan_n;

    logic       clk;
    logic       rst_n;
    logic       enable;
    logic       mode;
    logic [1:0] data_a;
    logic [2:0] data_b;
    logic [3:0] out_a;
    logic [1:0] idx_a;
    logic       val_a, wrap_a;
    logic [7:0] out_b;
    logic [2:0] idx_b;
    logic       val_b, wrap_b;

    int n_checks = 0;
    int n_fail   = 0;
    int cycle    = 0;

    // Reference model state: position in the sweep counted in enabled scan cycles.
    int          scan_t    [2];
    int          mode_prev [2];
    logic [63:0] e_out     [2];
    logic [63:0] e_idx     [2];
    logic        e_val     [2];
    logic        e_wrap    [2];

    decoder_scan_n #(
        .SEL_W (2),
        .DWELL (4)
    ) dut_a (
        .clk       (clk),
        .rst_n     (rst_n),
        .enable    (enable),
        .mode      (mode),
        .data_in   (data_a),
`ifdef DECODER_SCAN_SKIP_MASK_EN
        .skip_mask (4'b0000),
`endif
        .out       (out_a),
        .out_idx   (idx_a),
        .out_valid (val_a),
        .wrap      (wrap_a)
    );

    decoder_scan_n #(
        .SEL_W (3),
        .DWELL (1)
    ) dut_b (
        .clk       (clk),
        .rst_n     (rst_n),
        .enable    (enable),
        .mode      (mode),
        .data_in   (data_b),
`ifdef DECODER_SCAN_SKIP_MASK_EN
        .skip_mask (8'b0000_0000),
`endif
        .out       (out_b),
        .out_idx   (idx_b),
        .out_valid (val_b),
        .wrap      (wrap_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s cycle %0d: got 0x%0h expected 0x%0h", tag, cycle, obs, exp);
        end
    endtask

    // Expected outputs after the coming edge, from the mode/dwell/sweep rules.
    task automatic model(input int i, input int sel_w, input int dwell, input int d);
        int out_w;
        int line;
        out_w = 1 << sel_w;
        if (!rst_n) begin
            scan_t[i]    = 0;
            mode_prev[i] = 0;
            e_out[i]     = '0;
            e_idx[i]     = '0;
            e_val[i]     = 1'b0;
            e_wrap[i]    = 1'b0;
        end else if (!enable) begin
            e_out[i]  = '0;
            e_val[i]  = 1'b0;
            e_wrap[i] = 1'b0;
        end else begin
            if (int'(mode) != mode_prev[i]) begin
                scan_t[i]    = 0;
                mode_prev[i] = int'(mode);
            end
            if (!mode) begin
                e_out[i]  = 64'd1 << d;
                e_idx[i]  = 64'(d);
                e_val[i]  = 1'b1;
                e_wrap[i] = 1'b0;
            end else begin
                line      = (scan_t[i] / dwell) % out_w;
                e_out[i]  = 64'd1 << line;
                e_idx[i]  = 64'(line);
                e_val[i]  = 1'b1;
                e_wrap[i] = (scan_t[i] > 0) && ((scan_t[i] % (dwell * out_w)) == 0);
                scan_t[i]++;
            end
        end
    endtask

    task automatic step(input logic r, input logic e, input logic m,
                        input logic [1:0] da, input logic [2:0] db);
        rst_n  = r;
        enable = e;
        mode   = m;
        data_a = da;
        data_b = db;
        model(0, 2, 4, int'(da));
        model(1, 3, 1, int'(db));
        @(posedge clk);
        #1;
        cycle++;
        check_eq("a_out",   64'(out_a),  e_out[0]);
        check_eq("a_idx",   64'(idx_a),  e_idx[0]);
        check_eq("a_valid", 64'(val_a),  64'(e_val[0]));
        check_eq("a_wrap",  64'(wrap_a), 64'(e_wrap[0]));
        check_eq("b_out",   64'(out_b),  e_out[1]);
        check_eq("b_idx",   64'(idx_b),  e_idx[1]);
        check_eq("b_valid", 64'(val_b),  64'(e_val[1]));
        check_eq("b_wrap",  64'(wrap_b), 64'(e_wrap[1]));
    endtask

    initial begin
        logic m_cur;
        rst_n  = 1'b0;
        enable = 1'b0;
        mode   = 1'b0;
        data_a = '0;
        data_b = '0;
        for (int i = 0; i < 2; i++) begin
            scan_t[i]    = 0;
            mode_prev[i] = 0;
        end

        // Reset, then direct decodes.
        step(1'b0, 1'b0, 1'b0, 2'd0, 3'd0);
        step(1'b0, 1'b1, 1'b1, 2'd3, 3'd7);
        step(1'b1, 1'b1, 1'b0, 2'd2, 3'd5);
        step(1'b1, 1'b1, 1'b0, 2'd1, 3'd0);
        step(1'b1, 1'b1, 1'b0, 2'd3, 3'd7);

        // Full sweep with wrap on both instances.
        for (int k = 0; k < 18; k++) step(1'b1, 1'b1, 1'b1, 2'd0, 3'd0);

        // Back to direct, then scan to line 1 / dwell 2 and drop enable for 5 cycles.
        step(1'b1, 1'b1, 1'b0, 2'd0, 3'd1);
        for (int k = 0; k < 6; k++) step(1'b1, 1'b1, 1'b1, 2'd0, 3'd0);
        for (int k = 0; k < 5; k++) step(1'b1, 1'b0, 1'b1, 2'd0, 3'd0);
        for (int k = 0; k < 8; k++) step(1'b1, 1'b1, 1'b1, 2'd0, 3'd0);

        // Reset while scanning at line 3, then restart.
        step(1'b1, 1'b1, 1'b1, 2'd0, 3'd0);
        step(1'b0, 1'b1, 1'b1, 2'd0, 3'd0);
        for (int k = 0; k < 6; k++) step(1'b1, 1'b1, 1'b1, 2'd0, 3'd0);

        // Randomised control and data.
        m_cur = 1'b1;
        for (int k = 0; k < 800; k++) begin
            if ($urandom_range(0, 15) == 0) m_cur = ~m_cur;
            step(($urandom_range(0, 47) != 0), ($urandom_range(0, 7) != 0), m_cur,
                 2'($urandom_range(0, 3)), 3'($urandom_range(0, 7)));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
